// File: rtl/countdown_timer_pkg.sv
// Shared constants for the BCD MM:SS countdown timer: FSM encodings and digit limits.
package countdown_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] DIG_MAX_UNITS    = 4'd9;
    localparam logic [3:0] DIG_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the borrow chain: decrements on borrow_in, wraps 0 -> MAXV and borrows onward.
module bcd_down_digit #(
    parameter logic [3:0] MAXV = 4'd9
) (
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next,
    output logic       borrow_out
);

    assign borrow_out = borrow_in && (digit == 4'd0);
    assign next       = !borrow_in        ? digit :
                        (digit == 4'd0)   ? MAXV  : digit - 4'd1;

endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: prescaled 1 s tick drives a four-digit borrow chain under a small FSM.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CW       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] maxv);
        return (d > maxv) ? maxv : d;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          done_q, done_d;

    logic          tick;
    logic          count_zero;
    logic          reach_zero;
    logic [7:0]    min_dec, sec_dec;
    logic          b_su, b_st, b_mu, b_mt;

    // A pause in the same cycle as terminal count wins: the prescaler is frozen, no decrement.
    assign tick       = (state_q == ST_RUN) && !pause && (presc_q == TERM);
    assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign reach_zero = ({min_dec, sec_dec} == 16'h0000) && !b_mt;

    bcd_down_digit #(.MAXV(DIG_MAX_UNITS)) u_sec_units (
        .digit(sec_q[3:0]), .borrow_in(tick), .next(sec_dec[3:0]), .borrow_out(b_su)
    );
    bcd_down_digit #(.MAXV(DIG_MAX_SEC_TENS)) u_sec_tens (
        .digit(sec_q[7:4]), .borrow_in(b_su), .next(sec_dec[7:4]), .borrow_out(b_st)
    );
    bcd_down_digit #(.MAXV(DIG_MAX_UNITS)) u_min_units (
        .digit(min_q[3:0]), .borrow_in(b_st), .next(min_dec[3:0]), .borrow_out(b_mu)
    );
    bcd_down_digit #(.MAXV(DIG_MAX_UNITS)) u_min_tens (
        .digit(min_q[7:4]), .borrow_in(b_mu), .next(min_dec[7:4]), .borrow_out(b_mt)
    );

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        min_d   = min_q;
        sec_d   = sec_q;
        done_d  = 1'b0;
        if (state_q == ST_RUN) begin
            if (pause) begin
                state_d = ST_PAUSE;
            end else if (tick) begin
                presc_d = '0;
                min_d   = min_dec;
                sec_d   = sec_dec;
                if (reach_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + CW'(1);
            end
        end else if (load) begin
            min_d   = {clamp_digit(load_min[7:4], DIG_MAX_UNITS),
                       clamp_digit(load_min[3:0], DIG_MAX_UNITS)};
            sec_d   = {clamp_digit(load_sec[7:4], DIG_MAX_SEC_TENS),
                       clamp_digit(load_sec[3:0], DIG_MAX_UNITS)};
            state_d = ST_IDLE;
        end else if (start && !pause && (state_q != ST_DONE) && !count_zero) begin
            // A fresh start restarts the second; a resume continues the held prescaler.
            if (state_q == ST_IDLE) begin
                presc_d = '0;
            end
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            done_q  <= done_d;
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign running = (state_q == ST_RUN);
    assign expired = (state_q == ST_DONE);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random strobes against a seconds-based model.
module tb_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int CW       = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       expired;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: remaining time as a plain number of seconds, plus cycles elapsed in the current second.
    int m_state;
    int m_secs;
    int m_phase;
    bit m_done;

    countdown_timer #(.TICK_DIV(TICK_DIV), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_min(load_min), .load_sec(load_sec),
        .start(start), .pause(pause), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .running(running), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [7:0] exp_min();
        return to_bcd(m_secs / 60);
    endfunction

    function automatic logic [7:0] exp_sec();
        return to_bcd(m_secs % 60);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_secs  = 0;
        m_phase = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                              input bit st, input bit pa);
        m_done = 1'b0;
        if (m_state == M_RUN) begin
            if (pa) begin
                m_state = M_PAUSE;
            end else if (m_phase == TICK_DIV - 1) begin
                m_phase = 0;
                m_secs  = m_secs - 1;
                if (m_secs == 0) begin
                    m_state = M_DONE;
                    m_done  = 1'b1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (ld) begin
            m_secs  = (clampd(int'(lm[7:4]), 9) * 10 + clampd(int'(lm[3:0]), 9)) * 60
                    +  clampd(int'(ls[7:4]), 5) * 10 + clampd(int'(ls[3:0]), 9);
            m_state = M_IDLE;
        end else if (!pa && st && m_state != M_DONE && m_secs != 0) begin
            if (m_state == M_IDLE) m_phase = 0;
            m_state = M_RUN;
        end
    endtask

    // One clock: drive strobes from the falling edge, update the model on the rising edge.
    task automatic step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                        input bit st, input bit pa);
        load = ld; load_min = lm; load_sec = ls; start = st; pause = pa;
        @(posedge clk);
        model_step(ld, lm, ls, st, pa);
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("min_bcd", 32'(min_bcd), 32'(exp_min()));
            chk("sec_bcd", 32'(sec_bcd), 32'(exp_sec()));
            chk("running", 32'(running), 32'(m_state == M_RUN));
            chk("expired", 32'(expired), 32'(m_state == M_DONE));
            chk("done",    32'(done),    32'(m_done));
        end
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; load_min = 8'h00; load_sec = 8'h00;
        start = 1'b0; pause = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_min", 32'(min_bcd), 32'h00);
        chk("rst_running", 32'(running), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: 01:00 -> 00:59 -> 00:58
        step(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(3);
        chk("t1_pre_sec", 32'(sec_bcd), 32'h00);
        idle(1);
        chk("t1_min", 32'(min_bcd), 32'h00);
        chk("t1_sec", 32'(sec_bcd), 32'h59);
        chk("t1_model_sec", 32'(exp_sec()), 32'h59);
        chk("t1_running", 32'(running), 32'h1);
        idle(4);
        chk("t1_sec2", 32'(sec_bcd), 32'h58);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // 2: borrow through all four digits
        step(1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(4);
        chk("t2_min", 32'(min_bcd), 32'h09);
        chk("t2_sec", 32'(sec_bcd), 32'h59);
        chk("t2_model_min", 32'(exp_min()), 32'h09);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // 3: expiry, done pulse, DONE holds
        step(1'b1, 8'h00, 8'h02, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(4);
        chk("t3_sec1", 32'(sec_bcd), 32'h01);
        chk("t3_nodone", 32'(done), 32'h0);
        idle(4);
        chk("t3_sec0", 32'(sec_bcd), 32'h00);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_model_done", 32'(m_done), 32'h1);
        chk("t3_expired", 32'(expired), 32'h1);
        idle(1);
        chk("t3_done_drop", 32'(done), 32'h0);
        idle(20);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("t3_start_in_done", 32'(expired), 32'h1);
        chk("t3_not_running", 32'(running), 32'h0);

        // 4: pause holds the prescaler phase
        step(1'b1, 8'h00, 8'h05, 1'b0, 1'b0);
        chk("t4_exp_clear", 32'(expired), 32'h0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(10);
        chk("t4_frozen", 32'(sec_bcd), 32'h05);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(1);
        chk("t4_resume1", 32'(sec_bcd), 32'h05);
        idle(1);
        chk("t4_resume2", 32'(sec_bcd), 32'h04);

        // 5: start+pause in RUN, load ignored in RUN, load clamp
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("t5_paused", 32'(running), 32'h0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 8'h30, 1'b0, 1'b0);
        chk("t5_load_ignored", 32'(sec_bcd), 32'h04);
        chk("t5_still_run", 32'(running), 32'h1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'h7A, 1'b0, 1'b0);
        chk("t5_clamp_min", 32'(min_bcd), 32'h99);
        chk("t5_clamp_sec", 32'(sec_bcd), 32'h59);
        chk("t5_model_clamp", 32'(exp_sec()), 32'h59);

        // Random strobes, loads mostly short so expiry is reached often
        for (int i = 0; i < 600; i++) begin
            logic [7:0] lm, ls;
            lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ls = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            step($urandom_range(0, 9) == 0, lm, ls,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
        end

        // 6: asynchronous reset mid-RUN
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h00, 8'h03, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_min", 32'(min_bcd), 32'h00);
        chk("t6_sec", 32'(sec_bcd), 32'h00);
        chk("t6_running", 32'(running), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("t6_start_zero", 32'(running), 32'h0);
        idle(8);
        chk("t6_no_done", 32'(done), 32'h0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
